// File: rtl/dht_sensor_rx.sv
// Single-wire DHT-style humidity/temperature reader: issues the host start pulse,
// times the sensor's response and 40 data bits, then validates the checksum.
module dht_sensor_rx #(
    parameter int CLKS_PER_US    = 50,
    parameter int START_LOW_US   = 18000,
    parameter int BIT1_THRESH_US = 40,
    parameter int TIMEOUT_US     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic [7:0] humidity_out,
    output logic [7:0] temp_out,
    output logic       data_valid,
    output logic       err_cksum,
    output logic       err_timeout
);

    localparam logic [23:0] START_CYC   = 24'(START_LOW_US * CLKS_PER_US);
    localparam logic [23:0] BIT1_CYC    = 24'(BIT1_THRESH_US * CLKS_PER_US);
    localparam logic [23:0] TIMEOUT_CYC = 24'(TIMEOUT_US * CLKS_PER_US);
    // The synchronizer still shows our own start pulse for two cycles after release.
    localparam logic [23:0] SYNC_SETTLE = 24'd2;

    typedef enum logic [2:0] {
        IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
    } state_t;

    state_t      state_reg, state_next;
    logic        dq_meta_reg, dq_sync_reg;
    logic [23:0] cnt_reg;
    logic [5:0]  bit_idx_reg;
    logic [39:0] shift_reg;
    logic [7:0]  humidity_reg, temp_reg;
    logic        data_valid_reg, err_cksum_reg;
    logic        timeout_hit, bit_val;
    logic [7:0]  frame_byte [5];
    logic [7:0]  sum;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_bytes
            assign frame_byte[gi] = shift_reg[39 - 8*gi -: 8];
        end
    endgenerate

    assign sum     = frame_byte[0] + frame_byte[1] + frame_byte[2] + frame_byte[3];
    assign bit_val = (cnt_reg >= BIT1_CYC);  // high lasted cnt_reg+1 cycles when low is seen

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE:      if (start) state_next = START_LOW;
            START_LOW: if (cnt_reg == START_CYC - 24'd1) state_next = WAIT_RESP;
            WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: begin
                if (cnt_reg >= TIMEOUT_CYC) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    case (state_reg)
                        WAIT_RESP: if (cnt_reg >= SYNC_SETTLE && !dq_sync_reg) state_next = RESP_LOW;
                        RESP_LOW:  if (dq_sync_reg)  state_next = RESP_HIGH;
                        RESP_HIGH: if (!dq_sync_reg) state_next = BIT_LOW;
                        BIT_LOW:   if (dq_sync_reg)  state_next = BIT_HIGH;
                        BIT_HIGH:  if (!dq_sync_reg) state_next = (bit_idx_reg == 6'd39) ? CHECK : BIT_LOW;
                        default:   state_next = IDLE;
                    endcase
                end
            end
            CHECK:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_meta_reg    <= 1'b1;
            dq_sync_reg    <= 1'b1;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            humidity_reg   <= '0;
            temp_reg       <= '0;
            data_valid_reg <= 1'b0;
            err_cksum_reg  <= 1'b0;
        end else begin
            dq_meta_reg <= dq_in;
            dq_sync_reg <= dq_meta_reg;

            if (state_next != state_reg || state_reg == IDLE)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 24'd1;

            if (state_reg == RESP_HIGH && state_next == BIT_LOW)
                bit_idx_reg <= '0;
            else if (state_reg == BIT_HIGH && (state_next == BIT_LOW || state_next == CHECK)) begin
                shift_reg   <= {shift_reg[38:0], bit_val};
                bit_idx_reg <= bit_idx_reg + 6'd1;
            end

            data_valid_reg <= 1'b0;
            err_cksum_reg  <= 1'b0;
            if (state_reg == CHECK) begin
                if (sum == frame_byte[4]) begin
                    data_valid_reg <= 1'b1;
                    humidity_reg   <= (frame_byte[0] > 8'd100) ? 8'd100 : frame_byte[0];
                    temp_reg       <= frame_byte[2];
                end else begin
                    err_cksum_reg  <= 1'b1;
                end
            end
        end
    end

    assign dq_oe        = (state_reg == START_LOW);
    assign busy         = (state_reg != IDLE);
    assign humidity_out = humidity_reg;
    assign temp_out     = temp_reg;
    assign data_valid   = data_valid_reg;
    assign err_cksum    = err_cksum_reg;
    assign err_timeout  = timeout_hit;

endmodule

// File: tb/tb_dht_sensor_rx.sv
// Bench for dht_sensor_rx: a sensor model drives the wire, a scoreboard
// holds expected result events and a monitor checks them as they appear.
module tb_dht_sensor_rx;

    logic       clk, rst, start, dq_in;
    logic       dq_oe, busy, data_valid, err_cksum, err_timeout;
    logic [7:0] humidity_out, temp_out;
    logic       sensor_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;  // 0 data_valid, 1 err_cksum, 2 err_timeout
        logic [7:0] hum;
        logic [7:0] temp;
    } exp_t;
    exp_t exp_q [$];

    dht_sensor_rx #(
        .CLKS_PER_US(1), .START_LOW_US(100), .BIT1_THRESH_US(40), .TIMEOUT_US(200)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dq_in(dq_in), .dq_oe(dq_oe), .busy(busy),
        .humidity_out(humidity_out), .temp_out(temp_out), .data_valid(data_valid),
        .err_cksum(err_cksum), .err_timeout(err_timeout)
    );

    // Open-drain wire: either side can pull it low.
    assign dq_in = sensor_level & ~dq_oe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int hum, input int temp);
        exp_t e;
        e.kind = kind;
        e.hum  = 8'(hum);
        e.temp = 8'(temp);
        exp_q.push_back(e);
    endtask

    // Monitor: one scoreboard pop per result pulse.
    always @(negedge clk) begin
        if (!rst && (data_valid || err_cksum || err_timeout)) begin
            exp_t e;
            int   kind;
            kind = data_valid ? 0 : (err_cksum ? 1 : 2);
            check("pulse_exclusive", int'(data_valid) + int'(err_cksum) + int'(err_timeout), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_event", kind, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("humidity_out", humidity_out, e.hum);
                check("temp_out", temp_out, e.temp);
                $display("event kind=%0d hum=%0d temp=%0d", kind, humidity_out, temp_out);
            end
        end
    end

    task automatic drive(input logic level, input int cycles);
        sensor_level = level;
        repeat (cycles) @(negedge clk);
    endtask

    // Pulse start, re-pulse it while busy, and measure how long the bus is held low.
    task automatic start_and_measure(output int low_cycles);
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (dq_oe && n < 1000) begin
            n++;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        low_cycles = n;
    endtask

    task automatic sensor_frame(input logic [39:0] frame, input int h0, input int h1,
                                input int abort_bits);
        drive(1'b1, 20);
        drive(1'b0, 80);
        drive(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            if (i == abort_bits) begin
                sensor_level = 1'b1;
                return;
            end
            drive(1'b0, 50);
            drive(1'b1, frame[39 - i] ? h1 : h0);
        end
        drive(1'b0, 50);
        sensor_level = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic read_frame(input string name, input logic [39:0] frame,
                              input int h0, input int h1, input int abort_bits);
        int low;
        start_and_measure(low);
        check({name, "_start_low"}, low, 100);
        sensor_frame(frame, h0, h1, abort_bits);
        if (abort_bits >= 40) wait_idle({name, "_idle"});
        repeat (5) @(negedge clk);
        $display("transaction %s done", name);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        sensor_level = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dq_oe", dq_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_humidity", humidity_out, 0);
        check("rst_temp", temp_out, 0);
        check("rst_pulses", int'(data_valid) + int'(err_cksum) + int'(err_timeout), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal 55/0/24/0/79
        push(0, 55, 24);
        read_frame("nominal", {8'd55, 8'd0, 8'd24, 8'd0, 8'd79}, 27, 70, 40);

        // Bad checksum 60/0/20/0/81: outputs hold 55/24
        push(1, 55, 24);
        read_frame("cksum", {8'd60, 8'd0, 8'd20, 8'd0, 8'd81}, 27, 70, 40);

        // Humidity clamp 120/0/25/0/145
        push(0, 100, 25);
        read_frame("clamp", {8'd120, 8'd0, 8'd25, 8'd0, 8'd145}, 27, 70, 40);

        // No sensor: line stays high
        push(2, 100, 25);
        start_and_measure(n);
        check("nosensor_start_low", n, 100);
        n = 0;
        while (!err_timeout && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 200);
        check("timeout_busy_during", int'(busy), 1);
        @(negedge clk);
        check("timeout_busy_after", int'(busy), 0);
        repeat (5) @(negedge clk);
        $display("transaction timeout done");

        // Threshold boundary: 0-bits high 40 cycles, 1-bits high 41 cycles
        push(0, 33, 21);
        read_frame("thresh", {8'd33, 8'd0, 8'd21, 8'd0, 8'd54}, 40, 41, 40);

        // Reset after bit 20, then a full read
        read_frame("abort", {8'd55, 8'd0, 8'd24, 8'd0, 8'd79}, 27, 70, 21);
        check("abort_busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_dq_oe", dq_oe, 0);
        check("abort_busy", busy, 0);
        check("abort_humidity", humidity_out, 0);
        check("abort_temp", temp_out, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        push(0, 55, 24);
        read_frame("after_abort", {8'd55, 8'd0, 8'd24, 8'd0, 8'd79}, 27, 70, 40);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
